conv_seq_ctrl: RTL and testbench

Sequencer for the 1-D convolution MAC datapath. It sits between the X-memory write controller and the output AXI-stream port. Once the X vector is fully loaded, it walks the X-memory and F-ROM read addresses for each of the N-M+1 outputs and drives the multiply-register and accumulator enables/clear, aligned to the datapath pipeline. It presents each result with a valid/ready handshake, then pulses conv_done to release X-memory for the next vector.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_pipe_delay.sv | 23 ++
 rtl/conv_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution sequencer and its MAC datapath.
package conv_pkg;

    localparam int PIPE_LAT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT,
        DONE
    } conv_state_e;

    // Tag carried alongside each issued tap through the read/product pipeline.
    typedef struct packed {
        logic valid;
        logic first;
    } pipe_tag_t;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/conv_pipe_delay.sv
// Fixed-depth shift register; stage[k] is the input as it was k cycles earlier.
module conv_pipe_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [W-1:0]           din,
    output logic [DEPTH:1][W-1:0]  stage
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= '0;
        end else begin
            stage[1] <= din;
            for (int i = 2; i <= DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Walks X-memory / F-ROM addresses for each convolution output and drives the
// MAC enables in step with the datapath pipeline, then hands the result out.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int N        = 128,
    parameter int M        = 32,
    parameter int X_AW     = clog2_min1(N),
    parameter int F_AW     = clog2_min1(M),
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            conv_start,
    input  logic            m_ready_y,
    output logic [X_AW-1:0] xmem_addr,
    output logic [F_AW-1:0] fmem_addr,
    output logic            en_mult,
    output logic            en_accum,
    output logic            clr_accum,
    output logic            m_valid_y,
    output logic            conv_done,
    output logic            busy
);

    localparam int              DW       = clog2_min1(PIPE_LAT + 1);
    localparam int              TW       = $bits(pipe_tag_t);
    localparam logic [F_AW-1:0] TAP_LAST = F_AW'(M - 1);
    localparam logic [X_AW-1:0] OUT_LAST = X_AW'(N - M);

    if (N < M || M < 1 || PIPE_LAT < 1) begin : g_param_check
        $error("conv_seq_ctrl: requires N >= M >= 1 and PIPE_LAT >= 1");
    end

    conv_state_e            state, state_n;
    logic [X_AW-1:0]        out_idx, out_idx_n;
    logic [X_AW-1:0]        x_ptr, x_ptr_n;
    logic [F_AW-1:0]        tap, tap_n;
    logic [DW-1:0]          drain_cnt, drain_n;
    logic                   armed;
    logic                   m_valid_q, conv_done_q;
    pipe_tag_t              push, tag_mult, tag_acc;
    logic [PIPE_LAT:1][TW-1:0] stage;

    always_comb begin
        state_n   = state;
        out_idx_n = out_idx;
        x_ptr_n   = x_ptr;
        tap_n     = tap;
        drain_n   = drain_cnt;
        case (state)
            IDLE: begin
                if (conv_start && armed) begin
                    out_idx_n = '0;
                    x_ptr_n   = '0;
                    tap_n     = '0;
                    state_n   = RUN;
                end
            end
            RUN: begin
                // Hold the last tap so addresses stay frozen through DRAIN/OUT.
                if (tap == TAP_LAST) begin
                    drain_n = DW'(PIPE_LAT);
                    state_n = DRAIN;
                end else begin
                    tap_n   = tap + F_AW'(1);
                    x_ptr_n = x_ptr + X_AW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == DW'(1)) state_n = OUT;
                else                     drain_n = drain_cnt - DW'(1);
            end
            OUT: begin
                if (m_ready_y) begin
                    if (out_idx == OUT_LAST) begin
                        state_n = DONE;
                    end else begin
                        out_idx_n = out_idx + X_AW'(1);
                        x_ptr_n   = out_idx + X_AW'(1);
                        tap_n     = '0;
                        state_n   = RUN;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            out_idx     <= '0;
            x_ptr       <= '0;
            tap         <= '0;
            drain_cnt   <= '0;
            m_valid_q   <= 1'b0;
            conv_done_q <= 1'b0;
        end else begin
            state       <= state_n;
            out_idx     <= out_idx_n;
            x_ptr       <= x_ptr_n;
            tap         <= tap_n;
            drain_cnt   <= drain_n;
            m_valid_q   <= (state_n == OUT);
            conv_done_q <= (state_n == DONE);
        end
    end

    // A held-high start level must drop before it can launch another vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         armed <= 1'b1;
        else if (conv_done_q) armed <= 1'b0;
        else if (!conv_start) armed <= 1'b1;
    end

    always_comb begin
        push.valid = (state == RUN);
        push.first = (state == RUN) && (tap == '0);
    end

    conv_pipe_delay #(
        .DEPTH (PIPE_LAT),
        .W     (TW)
    ) u_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (push),
        .stage   (stage)
    );

    assign tag_mult  = pipe_tag_t'(stage[1]);
    assign tag_acc   = pipe_tag_t'(stage[PIPE_LAT]);
    assign en_mult   = tag_mult.valid;
    assign en_accum  = tag_acc.valid;
    assign clr_accum = tag_acc.first;

    assign xmem_addr = x_ptr;
    assign fmem_addr = tap;
    assign m_valid_y = m_valid_q;
    assign conv_done = conv_done_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: default-size instance against a timing model, plus
// a square N==M instance for the single-output corner.
module tb_conv_seq_ctrl;

    localparam int N  = 128;
    localparam int M  = 32;
    localparam int PL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, conv_start, m_ready_y;
    logic [6:0] xa;
    logic [4:0] fa;
    logic       en_mult, en_accum, clr_accum, m_valid_y, conv_done, busy;

    logic       rst_b, start_b, rdy_b;
    logic [1:0] xb, fb;
    logic       mult_b, acc_b, clr_b, vld_b, done_b, busy_b;

    conv_seq_ctrl #(.N(N), .M(M), .PIPE_LAT(PL)) u_a (
        .clk(clk), .reset_n(reset_n), .conv_start(conv_start), .m_ready_y(m_ready_y),
        .xmem_addr(xa), .fmem_addr(fa), .en_mult(en_mult), .en_accum(en_accum),
        .clr_accum(clr_accum), .m_valid_y(m_valid_y), .conv_done(conv_done), .busy(busy)
    );

    conv_seq_ctrl #(.N(4), .M(4), .PIPE_LAT(2)) u_b (
        .clk(clk), .reset_n(rst_b), .conv_start(start_b), .m_ready_y(rdy_b),
        .xmem_addr(xb), .fmem_addr(fb), .en_mult(mult_b), .en_accum(acc_b),
        .clr_accum(clr_b), .m_valid_y(vld_b), .conv_done(done_b), .busy(busy_b)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_xaddr"}, 32'(xa), 0);
        chk({tag, "_faddr"}, 32'(fa), 0);
        chk({tag, "_mult"},  32'(en_mult), 0);
        chk({tag, "_accum"}, 32'(en_accum), 0);
        chk({tag, "_clr"},   32'(clr_accum), 0);
        chk({tag, "_valid"}, 32'(m_valid_y), 0);
        chk({tag, "_done"},  32'(conv_done), 0);
        chk({tag, "_busy"},  32'(busy), 0);
    endtask

    // Model: within output j, t counts cycles from its RUN entry. Taps issue at
    // t=0..M-1, products capture at t+1, accumulate at t+PL, result valid from
    // t=M+PL until accepted; the next output's RUN begins right after acceptance.
    task automatic run_a(input int stop_j, input int stop_t, input bit rnd, output bit fin);
        int j = 0, t = 0, beats = 0, acc = 0, xmax = 0;
        bit rdy;
        fin = 0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            if (j == stop_j && t == stop_t) return;
            chk("a_xaddr", 32'(xa), (t < M) ? j + t : j + M - 1);
            chk("a_faddr", 32'(fa), (t < M) ? t : M - 1);
            chk("a_mult",  32'(en_mult),   32'(t >= 1 && t <= M));
            chk("a_accum", 32'(en_accum),  32'(t >= PL && t <= M + PL - 1));
            chk("a_clr",   32'(clr_accum), 32'(t == PL));
            chk("a_valid", 32'(m_valid_y), 32'(t >= M + PL));
            chk("a_done",  32'(conv_done), 0);
            chk("a_busy",  32'(busy), 1);
            if (en_accum) acc++;
            if (int'(xa) > xmax) xmax = int'(xa);
            if (j == 0 && t < M + PL + 10) rdy = 1'b0;
            else if (rnd)                  rdy = ($urandom_range(0, 3) != 0);
            else                           rdy = 1'b1;
            m_ready_y = rdy;
            if (rnd) conv_start = 1'($urandom_range(0, 1));
            tick();
            if (t >= M + PL && rdy) begin
                chk("a_accum_count", acc, M);
                acc = 0;
                beats++;
                if (j == N - M) begin
                    fin = 1;
                    break;
                end
                j++;
                t = 0;
            end else begin
                t++;
            end
        end
        chk("a_finished", 32'(fin), 1);
        if (fin) begin
            chk("a_beats", beats, N - M + 1);
            chk("a_xmax", xmax, N - 1);
            chk("a_done_pulse", 32'(conv_done), 1);
            chk("a_done_valid", 32'(m_valid_y), 0);
            conv_start = 1'b1;
            m_ready_y  = 1'($urandom_range(0, 1));
            tick();
            chk("a_done_clear", 32'(conv_done), 0);
            chk("a_done_idle", 32'(busy), 0);
        end
    endtask

    initial begin
        bit fin;
        reset_n = 1'b0; conv_start = 1'b0; m_ready_y = 1'b0;
        rst_b = 1'b0; start_b = 1'b0; rdy_b = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            conv_start = 1'($urandom_range(0, 1));
            m_ready_y  = 1'($urandom_range(0, 1));
            start_b    = 1'($urandom_range(0, 1));
            rdy_b      = 1'($urandom_range(0, 1));
            tick();
            chk_idle_a("rst");
            chk("rst_b_busy", 32'(busy_b), 0);
        end
        conv_start = 1'b0; m_ready_y = 1'b0; start_b = 1'b0; rdy_b = 1'b0;
        reset_n = 1'b1; rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_a("quiet");
        end

        // Full vector: random ready/start wiggle, backpressure on output 0.
        conv_start = 1'b1;
        tick();
        run_a(-1, 0, 1'b1, fin);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_retrigger_busy", 32'(busy), 0);
            chk("no_retrigger_valid", 32'(m_valid_y), 0);
        end

        // Rearm, then reset mid-sequence at output 3 tap 15.
        conv_start = 1'b0;
        tick();
        conv_start = 1'b1;
        tick();
        run_a(3, 15, 1'b0, fin);
        chk("pre_rst_xaddr", 32'(xa), 18);
        #2 reset_n = 1'b0;
        #1 chk_idle_a("midrst");
        for (int i = 0; i < 2; i++) begin
            conv_start = 1'($urandom_range(0, 1));
            m_ready_y  = 1'($urandom_range(0, 1));
            tick();
            chk_idle_a("midrst_hold");
        end
        conv_start = 1'b0; m_ready_y = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_a("post_rst");
        end
        conv_start = 1'b1;
        tick();
        chk("restart_busy", 32'(busy), 1);
        chk("restart_xaddr", 32'(xa), 0);
        chk("restart_faddr", 32'(fa), 0);
        chk("restart_mult", 32'(en_mult), 0);
        reset_n = 1'b0;

        // N == M: one output, 6 cycles to valid, done after the handshake.
        start_b = 1'b1; rdy_b = 1'b0;
        tick();
        for (int t = 0; t <= 8; t++) begin
            chk("b_xaddr", 32'(xb), (t < 4) ? t : 3);
            chk("b_faddr", 32'(fb), (t < 4) ? t : 3);
            chk("b_mult",  32'(mult_b), 32'(t >= 1 && t <= 4));
            chk("b_accum", 32'(acc_b),  32'(t >= 2 && t <= 5));
            chk("b_clr",   32'(clr_b),  32'(t == 2));
            chk("b_valid", 32'(vld_b),  32'(t >= 6));
            chk("b_done",  32'(done_b), 0);
            chk("b_busy",  32'(busy_b), 1);
            rdy_b = (t == 8);
            tick();
        end
        chk("b_done_pulse", 32'(done_b), 1);
        chk("b_done_valid", 32'(vld_b), 0);
        rdy_b = 1'b0;
        tick();
        chk("b_done_clear", 32'(done_b), 0);
        for (int i = 0; i < 4; i++) begin
            chk("b_no_retrigger", 32'(busy_b), 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
